// File: rtl/rsb_ctrl.sv
// rtl/rsb_ctrl.sv - return-stack controller with shadow depth and checkpointed flush unwind
//
// Sits in front of a DEPTH-entry return stack buffer. Call requests push the
// return address, return requests pop and predict from the RSB top, and a
// shadow depth is kept with one checkpoint per branch tag. A flush restores a
// checkpoint by popping one entry per cycle (UNWIND) until the depth matches.
//
// Optional feature macro: RSB_CTRL_COROUTINE_EN
//   defined   - call & ret together is a coroutine swap: pop now, push next
//               cycle from the CO_PUSH state.
//   undefined - call & ret together is handled as a plain call.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      fetch branch request handshake
//   req_call_i, req_ret_i          request classification
//   req_pc_i, req_cmp_i            branch PC, compressed (2-byte) flag
//   ckpt_valid_i, ckpt_tag_i       record post-request depth into a tag slot
//   flush_i, flush_tag_i           mispredict flush, checkpoint to restore
//   push_o, push_addr_o, pop_o     RSB control, combinational from request
//   top_i                          current RSB top entry
//   pred_valid_o, pred_target_o    return target prediction
//   depth_o                        shadow depth 0..DEPTH
//   recover_short_o                pulse: checkpoint deeper than current depth
module rsb_ctrl #(
    parameter  int DEPTH = 32,
    parameter  int TAGS  = 8,
    localparam int TAG_W = $clog2(TAGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_call_i,
    input  logic             req_ret_i,
    input  logic [63:0]      req_pc_i,
    input  logic             req_cmp_i,
    input  logic             ckpt_valid_i,
    input  logic [TAG_W-1:0] ckpt_tag_i,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] flush_tag_i,
    output logic             push_o,
    output logic [63:0]      push_addr_o,
    output logic             pop_o,
    input  logic [63:0]      top_i,
    output logic             pred_valid_o,
    output logic [63:0]      pred_target_o,
    output logic [5:0]       depth_o,
    output logic             recover_short_o
);

`ifdef RSB_CTRL_COROUTINE_EN
    typedef enum logic [1:0] {IDLE, UNWIND, CO_PUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, UNWIND} state_t;
`endif

    localparam logic [5:0] DEPTH_L = 6'(DEPTH);

    state_t     state_q, state_d;
    logic [5:0] depth_q, depth_d;
    logic [5:0] tgt_q, tgt_d;
    logic [5:0] tbl_q [TAGS];
    logic [5:0] tbl_d [TAGS];
    logic [5:0] depth_inc;
    logic [5:0] flush_tgt;
    logic [63:0] ret_addr;
    logic       do_call;
    logic       do_ret;
`ifdef RSB_CTRL_COROUTINE_EN
    logic [63:0] co_addr_q, co_addr_d;
`endif

    assign depth_o = depth_q;

    always_comb begin
        state_d         = state_q;
        depth_d         = depth_q;
        tgt_d           = tgt_q;
        tbl_d           = tbl_q;
        req_ready_o     = 1'b0;
        push_o          = 1'b0;
        push_addr_o     = '0;
        pop_o           = 1'b0;
        pred_valid_o    = 1'b0;
        pred_target_o   = '0;
        recover_short_o = 1'b0;
`ifdef RSB_CTRL_COROUTINE_EN
        co_addr_d       = co_addr_q;
        do_call         = req_call_i & ~req_ret_i;
        do_ret          = req_ret_i;
`else
        do_call         = req_call_i;
        do_ret          = req_ret_i & ~req_call_i;
`endif
        // The RSB overwrites its oldest entry on overflow, so depth saturates.
        depth_inc = (depth_q == DEPTH_L) ? DEPTH_L : depth_q + 6'd1;
        ret_addr  = req_pc_i + (req_cmp_i ? 64'd2 : 64'd4);
        flush_tgt = tbl_q[flush_tag_i];

        if (flush_i) begin
            // Flush overrides everything this cycle, including a pending
            // coroutine push and the checkpoint write.
            if (depth_q > flush_tgt) begin
                state_d = UNWIND;
                tgt_d   = flush_tgt;
            end else begin
                state_d         = IDLE;
                recover_short_o = (depth_q < flush_tgt);
            end
        end else begin
            case (state_q)
                UNWIND: begin
                    pop_o   = 1'b1;
                    depth_d = depth_q - 6'd1;
                    if (depth_d == tgt_q) begin
                        state_d = IDLE;
                    end
                end
`ifdef RSB_CTRL_COROUTINE_EN
                CO_PUSH: begin
                    push_o      = 1'b1;
                    push_addr_o = co_addr_q;
                    depth_d     = depth_inc;
                    state_d     = IDLE;
                end
`endif
                default: begin
                    req_ready_o = 1'b1;
                    if (req_valid_i) begin
                        if (do_call) begin
                            push_o      = 1'b1;
                            push_addr_o = ret_addr;
                            depth_d     = depth_inc;
                        end
                        if (do_ret) begin
                            pred_valid_o = 1'b1;
                            if (depth_q != 6'd0) begin
                                pop_o         = 1'b1;
                                pred_target_o = top_i;
                                depth_d       = depth_q - 6'd1;
                            end
                        end
`ifdef RSB_CTRL_COROUTINE_EN
                        if (req_call_i && req_ret_i) begin
                            state_d   = CO_PUSH;
                            co_addr_d = ret_addr;
                        end
`endif
                    end
                end
            endcase
            if (ckpt_valid_i) begin
                tbl_d[ckpt_tag_i] = depth_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            depth_q <= '0;
            tgt_q   <= '0;
            for (int i = 0; i < TAGS; i++) begin
                tbl_q[i] <= '0;
            end
`ifdef RSB_CTRL_COROUTINE_EN
            co_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            tgt_q   <= tgt_d;
            tbl_q   <= tbl_d;
`ifdef RSB_CTRL_COROUTINE_EN
            co_addr_q <= co_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_rsb_ctrl.sv
// tb/tb_rsb_ctrl.sv - randomized self-checking bench for rsb_ctrl against a stack-level model
module tb_rsb_ctrl;

`ifdef RSB_CTRL_COROUTINE_EN
    localparam bit CO = 1'b1;
`else
    localparam bit CO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_call_i, req_ret_i, req_cmp_i;
    logic [63:0] req_pc_i;
    logic        ckpt_valid_i, flush_i;
    logic [2:0]  ckpt_tag_i, flush_tag_i;
    logic        push_o, pop_o, pred_valid_o, recover_short_o;
    logic [63:0] push_addr_o, top_i, pred_target_o;
    logic [5:0]  depth_o;

    always #5 clk = ~clk;

    rsb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_call_i(req_call_i), .req_ret_i(req_ret_i),
        .req_pc_i(req_pc_i), .req_cmp_i(req_cmp_i),
        .ckpt_valid_i(ckpt_valid_i), .ckpt_tag_i(ckpt_tag_i),
        .flush_i(flush_i), .flush_tag_i(flush_tag_i),
        .push_o(push_o), .push_addr_o(push_addr_o), .pop_o(pop_o),
        .top_i(top_i), .pred_valid_o(pred_valid_o), .pred_target_o(pred_target_o),
        .depth_o(depth_o), .recover_short_o(recover_short_o)
    );

    // Reference: the RSB itself as a queue of return addresses (back = top).
    logic [63:0] stk[$];
    int          tbl[8];
    int          owed;
    bit          co_pend;
    logic [63:0] co_addr;

    int n_cmp = 0;
    int n_err = 0;
    int pops_seen, nrdy_seen, rs_seen;
    logic [63:0] last_pt, last_pa;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        foreach (tbl[i]) tbl[i] = 0;
        owed    = 0;
        co_pend = 0;
    endtask

    task automatic stk_push(input logic [63:0] a);
        stk.push_back(a);
        if (stk.size() > 32) void'(stk.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_i = 0; req_call_i = 0; req_ret_i = 0; req_pc_i = '0; req_cmp_i = 0;
        ckpt_valid_i = 0; ckpt_tag_i = '0; flush_i = 0; flush_tag_i = '0; top_i = '0;
        #1;
        chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst_push", {63'd0, push_o}, 64'd0);
        chk("rst_pop", {63'd0, pop_o}, 64'd0);
        chk("rst_pvalid", {63'd0, pred_valid_o}, 64'd0);
        chk("rst_short", {63'd0, recover_short_o}, 64'd0);
        chk("rst_paddr", push_addr_o, 64'd0);
        chk("rst_ptgt", pred_target_o, 64'd0);
        chk("rst_depth", {58'd0, depth_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: drive at negedge, predict from the stack model, compare at +1.
    task automatic step(input bit v, input bit c, input bit r, input logic [63:0] pc,
                        input bit cmp, input bit ckv, input logic [2:0] ckt,
                        input bit fl, input logic [2:0] flt);
        logic e_rdy, e_push, e_pop, e_pv, e_rs;
        logic [63:0] e_pa, e_pt, ra;
        int d, tgt;
        req_valid_i = v; req_call_i = c; req_ret_i = r; req_pc_i = pc; req_cmp_i = cmp;
        ckpt_valid_i = ckv; ckpt_tag_i = ckt; flush_i = fl; flush_tag_i = flt;
        top_i = (stk.size() > 0) ? stk[$] : {$urandom, $urandom};
        d = stk.size();
        e_rdy = 0; e_push = 0; e_pop = 0; e_pv = 0; e_rs = 0; e_pa = '0; e_pt = '0;
        if (fl) begin
            tgt     = tbl[flt];
            owed    = (d > tgt) ? d - tgt : 0;
            e_rs    = (d < tgt);
            co_pend = 0;
        end else if (owed > 0) begin
            e_pop = 1;
            void'(stk.pop_back());
            owed--;
        end else if (co_pend) begin
            e_push  = 1;
            e_pa    = co_addr;
            stk_push(co_addr);
            co_pend = 0;
        end else begin
            e_rdy = 1;
            if (v) begin
                ra = pc + (cmp ? 64'd2 : 64'd4);
                if (c && !(r && CO)) begin
                    e_push = 1;
                    e_pa   = ra;
                    stk_push(ra);
                end else if (r) begin
                    e_pv = 1;
                    if (d > 0) begin
                        e_pop = 1;
                        e_pt  = stk[$];
                        void'(stk.pop_back());
                    end
                    if (c) begin
                        co_pend = 1;
                        co_addr = ra;
                    end
                end
            end
        end
        if (!fl && ckv) tbl[ckt] = stk.size();
        #1;
        chk("ready", {63'd0, req_ready_o}, {63'd0, e_rdy});
        chk("push", {63'd0, push_o}, {63'd0, e_push});
        chk("push_addr", push_addr_o, e_pa);
        chk("pop", {63'd0, pop_o}, {63'd0, e_pop});
        chk("pred_valid", {63'd0, pred_valid_o}, {63'd0, e_pv});
        chk("pred_target", pred_target_o, e_pt);
        chk("recover_short", {63'd0, recover_short_o}, {63'd0, e_rs});
        chk("depth", {58'd0, depth_o}, 64'(d));
        pops_seen += int'(pop_o);
        nrdy_seen += int'(!req_ready_o);
        rs_seen   += int'(recover_short_o);
        last_pt = pred_target_o;
        last_pa = push_addr_o;
        @(negedge clk);
    endtask

    task automatic call(input logic [63:0] pc, input bit cmp);
        step(1, 1, 0, pc, cmp, 0, 0, 0, 0);
    endtask

    task automatic ret();
        step(1, 0, 1, 64'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input bit ckv, input logic [2:0] ckt, input bit fl, input logic [2:0] flt);
        step(0, 0, 0, 64'h0, 0, ckv, ckt, fl, flt);
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        call(64'h1000, 0);
        chk("call_addr", last_pa, 64'h1004);
        chk("call_depth", {58'd0, depth_o}, 64'd1);
        ret();

        call(64'h100, 0);
        call(64'h200, 1);
        ret();
        chk("ret1_tgt", last_pt, 64'h202);
        ret();
        chk("ret2_tgt", last_pt, 64'h104);
        chk("ret2_depth", {58'd0, depth_o}, 64'd0);
        pops_seen = 0;
        ret();
        chk("ret0_pop", 64'(pops_seen), 64'd0);
        chk("ret0_tgt", last_pt, 64'd0);

        // Flush with unwind of three speculative pushes.
        call(64'h10, 0);
        call(64'h20, 0);
        idle(1, 3, 0, 0);
        call(64'h30, 0);
        call(64'h40, 0);
        call(64'h50, 0);
        pops_seen = 0; nrdy_seen = 0;
        idle(0, 0, 1, 3);
        for (int i = 0; i < 4; i++) idle(0, 0, 0, 0);
        chk("unwind_pops", 64'(pops_seen), 64'd3);
        chk("unwind_nrdy", 64'(nrdy_seen), 64'd4);
        chk("unwind_depth", {58'd0, depth_o}, 64'd2);

        // Checkpoint deeper than the depth at flush time.
        call(64'h60, 0);
        call(64'h70, 0);
        idle(1, 1, 0, 0);
        ret();
        ret();
        pops_seen = 0; rs_seen = 0;
        idle(0, 0, 1, 1);
        idle(0, 0, 0, 0);
        idle(0, 0, 0, 0);
        chk("short_pulse", 64'(rs_seen), 64'd1);
        chk("short_pops", 64'(pops_seen), 64'd0);
        chk("short_depth", {58'd0, depth_o}, 64'd2);

`ifdef RSB_CTRL_COROUTINE_EN
        do_reset();
        call(64'h4FC, 0);
        step(1, 1, 1, 64'h800, 0, 0, 0, 0, 0);
        chk("co_tgt", last_pt, 64'h500);
        idle(0, 0, 0, 0);
        chk("co_push", last_pa, 64'h804);
        chk("co_depth", {58'd0, depth_o}, 64'd1);
`endif

        // Overflow: 34 pushes saturate at 32, then pops return newest first.
        do_reset();
        for (int i = 0; i < 34; i++) call(64'h1_0000 + 64'(i * 16), 0);
        chk("ovf_depth", {58'd0, depth_o}, 64'd32);
        ret();
        chk("ovf_tgt", last_pt, 64'h1_0000 + 64'd33 * 16 + 4);

        // Reset in the middle of an unwind (all checkpoints are 0 here).
        idle(0, 0, 1, 0);
        idle(0, 0, 0, 0);
        do_reset();

        for (int ph = 0; ph < 15; ph++) begin
            int bias;
            bias = $urandom_range(10, 90);
            for (int k = 0; k < 200; k++) begin
                bit v, c, r, cmp, ckv, fl;
                v   = ($urandom_range(0, 99) < 80);
                c   = ($urandom_range(0, 99) < bias);
                r   = ($urandom_range(0, 99) < 100 - bias);
                cmp = $urandom_range(0, 1) != 0;
                ckv = ($urandom_range(0, 99) < 10);
                fl  = ($urandom_range(0, 99) < 3);
                step(v, c, r, {$urandom, $urandom} & ~64'h1, cmp, ckv,
                     3'($urandom_range(0, 7)), fl, 3'($urandom_range(0, 7)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
